// File: rtl/stack_pkg.sv
// Shared codes, tags and helpers for the stack access unit.
package stack_pkg;

    // Sequencer phase codes.
    typedef enum logic [1:0] {
        PH_IDLE  = 2'b00,
        PH_PCLO  = 2'b01,
        PH_PCHI  = 2'b10,
        PH_FLAGS = 2'b11
    } seq_phase_e;

    // Sequencer direction codes; 2'b01 is unused and treated as no access.
    typedef enum logic [1:0] {
        DIR_NONE = 2'b00,
        DIR_PUSH = 2'b10,
        DIR_POP  = 2'b11
    } seq_dir_e;

    // Position of a sequencer pop within the current multi-word sequence.
    typedef logic [1:0] pop_idx_t;
    localparam pop_idx_t POP_IDX_PC_LO = 2'd0;
    localparam pop_idx_t POP_IDX_PC_HI = 2'd1;
    localparam pop_idx_t POP_IDX_FLAGS = 2'd2;
    localparam pop_idx_t POP_IDX_DONE  = 2'd3;

    // Destination of a word returning from memory one cycle after its pop.
    typedef enum logic [2:0] {
        CAP_NONE,
        CAP_SINGLE,
        CAP_PC_LO,
        CAP_PC_HI,
        CAP_FLAGS
    } cap_kind_e;

    // Empty-stack pointer: the top word of the address space.
    function automatic int unsigned sp_reset_for(input int unsigned addr_w);
        return (32'd1 << addr_w) - 32'd1;
    endfunction

endpackage

// File: rtl/stack_pointer_reg.sv
// Stack pointer register with increment/decrement and optional bounds checking.
// Bounds checking is enabled by defining STACK_BOUNDS_CHECK_EN.
module stack_pointer_reg
    import stack_pkg::*;
#(
    parameter int unsigned ADDR_W   = 11,
    parameter int unsigned SP_RESET = sp_reset_for(ADDR_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic              i_pop,
    output logic [ADDR_W-1:0] o_sp,
    output logic [ADDR_W-1:0] o_sp_inc,
    output logic              o_push_ok,
    output logic              o_pop_ok,
    output logic              o_stack_err
);

    localparam logic [ADDR_W-1:0] SP_RESET_VAL = ADDR_W'(SP_RESET);

    logic [ADDR_W-1:0] r_sp;

    assign o_sp     = r_sp;
    assign o_sp_inc = r_sp + ADDR_W'(1);

`ifdef STACK_BOUNDS_CHECK_EN
    logic r_stack_err;

    // A push into address 0 or a pop from the empty stack is blocked.
    assign o_push_ok   = (r_sp != '0);
    assign o_pop_ok    = (r_sp != SP_RESET_VAL);
    assign o_stack_err = r_stack_err;

    // Sticky error on any blocked access; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stack_err <= 1'b0;
        end else if ((i_push && !o_push_ok) || (i_pop && !o_pop_ok)) begin
            r_stack_err <= 1'b1;
        end
    end
`else
    // Unchecked: the pointer wraps modulo the address space.
    assign o_push_ok   = 1'b1;
    assign o_pop_ok    = 1'b1;
    assign o_stack_err = 1'b0;
`endif

    // Stack grows down; push has priority should both ever be requested.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sp <= SP_RESET_VAL;
        end else if (i_push && o_push_ok) begin
            r_sp <= r_sp - ADDR_W'(1);
        end else if (i_pop && o_pop_ok) begin
            r_sp <= o_sp_inc;
        end
    end

endmodule

// File: rtl/stack_access_unit.sv
// Memory-stage stack datapath: drives stack memory accesses for the sequencer and for
// single PUSH/POP requests, and reassembles popped PC/flags/data words.
// Bounds checking is enabled by defining STACK_BOUNDS_CHECK_EN.
module stack_access_unit
    import stack_pkg::*;
#(
    parameter int unsigned ADDR_W   = 11,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned PC_W     = 32,
    parameter int unsigned FLAG_W   = 3,
    parameter int unsigned SP_RESET = sp_reset_for(ADDR_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        seq_phase,
    input  logic [1:0]        seq_dir,
    input  logic [PC_W-1:0]   pc_in,
    input  logic [FLAG_W-1:0] flags_in,
    input  logic              push_req,
    input  logic              pop_req,
    input  logic [DATA_W-1:0] push_data,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] sp,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic [PC_W-1:0]   pc_out,
    output logic              pc_valid,
    output logic [FLAG_W-1:0] flags_out,
    output logic              flags_valid,
    output logic              stack_err
);

    logic              w_seq_act;
    logic              w_push;
    logic              w_pop;
    logic              w_push_ok;
    logic              w_pop_ok;
    logic [ADDR_W-1:0] w_sp;
    logic [ADDR_W-1:0] w_sp_inc;
    logic [DATA_W-1:0] w_push_word;
    logic [DATA_W-1:0] w_rdata;
    cap_kind_e         w_cap_kind;
    pop_idx_t          w_pop_idx_d;

    cap_kind_e         r_cap_kind;
    logic              r_cap_zero;
    pop_idx_t          r_pop_idx;
    logic [DATA_W-1:0] r_pop_data;
    logic              r_pop_valid;
    logic [PC_W-1:0]   r_pc;
    logic              r_pc_valid;
    logic [FLAG_W-1:0] r_flags;
    logic              r_flags_valid;

    assign w_seq_act = (seq_phase != PH_IDLE);

    stack_pointer_reg #(
        .ADDR_W   (ADDR_W),
        .SP_RESET (SP_RESET)
    ) u_sp (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .o_sp        (w_sp),
        .o_sp_inc    (w_sp_inc),
        .o_push_ok   (w_push_ok),
        .o_pop_ok    (w_pop_ok),
        .o_stack_err (stack_err)
    );

    // Decode the access for this cycle; an active sequencer phase locks out single
    // requests, and nothing is issued while reset is held.
    always_comb begin
        w_push = 1'b0;
        w_pop  = 1'b0;
        if (rst_n) begin
            if (w_seq_act) begin
                w_push = (seq_dir == DIR_PUSH);
                w_pop  = (seq_dir == DIR_POP);
            end else begin
                w_push = push_req;
                w_pop  = pop_req && !push_req;
            end
        end
    end

    // Select the word to push from the current phase.
    always_comb begin
        case (seq_phase_e'(seq_phase))
            PH_FLAGS: w_push_word = DATA_W'(flags_in);
            PH_PCHI:  w_push_word = pc_in[PC_W-1 -: DATA_W];
            PH_PCLO:  w_push_word = pc_in[DATA_W-1:0];
            default:  w_push_word = push_data;
        endcase
    end

    // Drive memory strobes, address and write data; idle outputs are zero.
    always_comb begin
        mem_we    = w_push && w_push_ok;
        mem_re    = w_pop && w_pop_ok;
        mem_addr  = '0;
        mem_wdata = '0;
        if (mem_we) begin
            mem_addr  = w_sp;
            mem_wdata = w_push_word;
        end else if (mem_re) begin
            mem_addr = w_sp_inc;
        end
    end

    // Tag each pop with where its data goes, and advance the sequencer pop index.
    always_comb begin
        w_cap_kind  = CAP_NONE;
        w_pop_idx_d = r_pop_idx;
        if (w_pop) begin
            if (!w_seq_act) begin
                w_cap_kind = CAP_SINGLE;
            end else begin
                case (r_pop_idx)
                    POP_IDX_PC_LO: w_cap_kind = CAP_PC_LO;
                    POP_IDX_PC_HI: w_cap_kind = CAP_PC_HI;
                    POP_IDX_FLAGS: w_cap_kind = CAP_FLAGS;
                    default:       w_cap_kind = CAP_NONE;
                endcase
            end
        end
        if (!w_seq_act) begin
            w_pop_idx_d = POP_IDX_PC_LO;
        end else if (w_pop && (r_pop_idx != POP_IDX_DONE)) begin
            w_pop_idx_d = r_pop_idx + pop_idx_t'(1);
        end
    end

    // A blocked pop still completes its capture, returning zero.
    assign w_rdata = r_cap_zero ? '0 : mem_rdata;

    // Hold the pop tag for one cycle so it lines up with mem_rdata.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cap_kind <= CAP_NONE;
            r_cap_zero <= 1'b0;
            r_pop_idx  <= POP_IDX_PC_LO;
        end else begin
            r_cap_kind <= w_cap_kind;
            r_cap_zero <= w_pop && !w_pop_ok;
            r_pop_idx  <= w_pop_idx_d;
        end
    end

    // Capture returned words into their destinations and pulse the matching valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pop_data    <= '0;
            r_pop_valid   <= 1'b0;
            r_pc          <= '0;
            r_pc_valid    <= 1'b0;
            r_flags       <= '0;
            r_flags_valid <= 1'b0;
        end else begin
            r_pop_valid   <= 1'b0;
            r_pc_valid    <= 1'b0;
            r_flags_valid <= 1'b0;
            case (r_cap_kind)
                CAP_SINGLE: begin
                    r_pop_data  <= w_rdata;
                    r_pop_valid <= 1'b1;
                end
                CAP_PC_LO: r_pc[DATA_W-1:0] <= w_rdata;
                CAP_PC_HI: begin
                    r_pc[PC_W-1 -: DATA_W] <= w_rdata;
                    r_pc_valid             <= 1'b1;
                end
                CAP_FLAGS: begin
                    r_flags       <= w_rdata[FLAG_W-1:0];
                    r_flags_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign sp          = w_sp;
    assign pop_data    = r_pop_data;
    assign pop_valid   = r_pop_valid;
    assign pc_out      = r_pc;
    assign pc_valid    = r_pc_valid;
    assign flags_out   = r_flags;
    assign flags_valid = r_flags_valid;

endmodule

// File: tb/tb_stack_access_unit.sv
// Self-checking bench for stack_access_unit with a registered-read memory model.
module tb_stack_access_unit;

    logic        clk;
    logic        rst_n;
    logic [1:0]  seq_phase;
    logic [1:0]  seq_dir;
    logic [31:0] pc_in;
    logic [2:0]  flags_in;
    logic        push_req;
    logic        pop_req;
    logic [15:0] push_data;
    logic [15:0] mem_rdata;
    logic [10:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [10:0] sp;
    logic [15:0] pop_data;
    logic        pop_valid;
    logic [31:0] pc_out;
    logic        pc_valid;
    logic [2:0]  flags_out;
    logic        flags_valid;
    logic        stack_err;

    logic        clr;
    logic [15:0] mem [0:2047];
    int          n_checks;
    int          n_errors;

`ifdef STACK_BOUNDS_CHECK_EN
    localparam int RE_UF  = 0;
    localparam int SP_UF  = 2047;
    localparam int ERR_UF = 1;
`else
    localparam int RE_UF  = 1;
    localparam int SP_UF  = 0;
    localparam int ERR_UF = 0;
`endif

    stack_access_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seq_phase   (seq_phase),
        .seq_dir     (seq_dir),
        .pc_in       (pc_in),
        .flags_in    (flags_in),
        .push_req    (push_req),
        .pop_req     (pop_req),
        .push_data   (push_data),
        .mem_rdata   (mem_rdata),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_re      (mem_re),
        .sp          (sp),
        .pop_data    (pop_data),
        .pop_valid   (pop_valid),
        .pc_out      (pc_out),
        .pc_valid    (pc_valid),
        .flags_out   (flags_out),
        .flags_valid (flags_valid),
        .stack_err   (stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: write on we, read data appears the cycle after re.
    always @(posedge clk) begin
        if (clr) begin
            for (int k = 0; k < 2048; k++) mem[k] <= 16'h0000;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem_re ? mem[mem_addr] : 16'hDEAD;
    end

    typedef struct {
        logic        rst;
        logic [1:0]  ph;
        logic [1:0]  dir;
        logic        push;
        logic        pop;
        logic [15:0] pd;
        logic        we;
        logic        re;
        logic [10:0] addr;
        logic [15:0] wd;
        logic [10:0] sp;
        logic [2:0]  vld;  // {pop_valid, pc_valid, flags_valid}
        logic        err;
    } vec_t;

    typedef struct {
        int          row;
        logic [15:0] pd;
        logic [31:0] pc;
        logic [2:0]  fl;
    } dchk_t;

    localparam int NV = 38;
    localparam int ND = 6;
    vec_t  tv [NV];
    dchk_t dc [ND];

    function automatic vec_t mk(int r, int ph, int dir, int pu, int po, int pd, int we,
                                int re, int addr, int wd, int spv, int vld, int err);
        vec_t v;
        v.rst  = 1'(r);    v.ph = 2'(ph);     v.dir = 2'(dir);
        v.push = 1'(pu);   v.pop = 1'(po);    v.pd  = 16'(pd);
        v.we   = 1'(we);   v.re = 1'(re);     v.addr = 11'(addr);
        v.wd   = 16'(wd);  v.sp = 11'(spv);   v.vld = 3'(vld);
        v.err  = 1'(err);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic single(input logic pu, input logic po, input logic [15:0] pd);
        @(negedge clk);
        rst_n = 1'b1; seq_phase = 2'b00; seq_dir = 2'b00;
        push_req = pu; pop_req = po; push_data = pd;
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_errors = 0;
        rst_n = 1'b0; seq_phase = 2'b00; seq_dir = 2'b00; pc_in = 32'h0;
        flags_in = 3'b000; push_req = 1'b0; pop_req = 1'b0; push_data = 16'h0;
        clr = 1'b1;

        //            r ph dr pu po pd      we re addr wd      sp    vld    err
        tv[0]  = mk(0, 0, 0, 0, 0, 0,      0, 0, 0,    0,      2047, 0,     0);
        tv[1]  = mk(1, 3, 2, 0, 0, 0,      1, 0, 2047, 'h0005, 2047, 0,     0);
        tv[2]  = mk(1, 2, 2, 0, 0, 0,      1, 0, 2046, 'h0001, 2046, 0,     0);
        tv[3]  = mk(1, 1, 2, 0, 0, 0,      1, 0, 2045, 'h2345, 2045, 0,     0);
        tv[4]  = mk(1, 0, 0, 0, 0, 0,      0, 0, 0,    0,      2044, 0,     0);
        tv[5]  = mk(1, 3, 3, 0, 0, 0,      0, 1, 2045, 0,      2044, 0,     0);
        tv[6]  = mk(1, 2, 3, 0, 0, 0,      0, 1, 2046, 0,      2045, 0,     0);
        tv[7]  = mk(1, 1, 3, 0, 0, 0,      0, 1, 2047, 0,      2046, 0,     0);
        tv[8]  = mk(1, 0, 0, 0, 0, 0,      0, 0, 0,    0,      2047, 'b010, 0);
        tv[9]  = mk(1, 0, 0, 0, 0, 0,      0, 0, 0,    0,      2047, 'b001, 0);
        tv[10] = mk(1, 0, 0, 0, 0, 0,      0, 0, 0,    0,      2047, 0,     0);
        tv[11] = mk(1, 2, 2, 0, 0, 0,      1, 0, 2047, 'h0001, 2047, 0,     0);
        tv[12] = mk(1, 1, 2, 0, 0, 0,      1, 0, 2046, 'h2345, 2046, 0,     0);
        tv[13] = mk(1, 0, 0, 0, 0, 0,      0, 0, 0,    0,      2045, 0,     0);
        tv[14] = mk(1, 2, 3, 0, 0, 0,      0, 1, 2046, 0,      2045, 0,     0);
        tv[15] = mk(1, 1, 3, 0, 0, 0,      0, 1, 2047, 0,      2046, 0,     0);
        tv[16] = mk(1, 0, 0, 0, 0, 0,      0, 0, 0,    0,      2047, 0,     0);
        tv[17] = mk(1, 0, 0, 0, 0, 0,      0, 0, 0,    0,      2047, 'b010, 0);
        tv[18] = mk(1, 2, 0, 1, 0, 'hBEEF, 0, 0, 0,    0,      2047, 0,     0);
        tv[19] = mk(1, 0, 0, 1, 1, 'hBEEF, 1, 0, 2047, 'hBEEF, 2047, 0,     0);
        tv[20] = mk(1, 0, 0, 0, 1, 0,      0, 1, 2047, 0,      2046, 0,     0);
        tv[21] = mk(1, 0, 0, 0, 0, 0,      0, 0, 0,    0,      2047, 0,     0);
        tv[22] = mk(1, 0, 0, 0, 0, 0,      0, 0, 0,    0,      2047, 'b100, 0);
        tv[23] = mk(1, 0, 0, 0, 0, 0,      0, 0, 0,    0,      2047, 0,     0);
        tv[24] = mk(1, 1, 0, 0, 1, 0,      0, 0, 0,    0,      2047, 0,     0);
        tv[25] = mk(1, 0, 0, 0, 1, 0,      0, RE_UF, 0, 0,     2047, 0,     0);
        tv[26] = mk(1, 0, 0, 0, 0, 0,      0, 0, 0,    0,      SP_UF, 0,    ERR_UF);
        tv[27] = mk(1, 0, 0, 0, 0, 0,      0, 0, 0,    0,      SP_UF, 'b100, ERR_UF);
        tv[28] = mk(0, 0, 0, 0, 0, 0,      0, 0, 0,    0,      SP_UF, 0,    ERR_UF);
        tv[29] = mk(1, 0, 0, 0, 0, 0,      0, 0, 0,    0,      2047, 0,     0);
        tv[30] = mk(1, 3, 2, 0, 0, 0,      1, 0, 2047, 'h0002, 2047, 0,     0);
        tv[31] = mk(1, 2, 2, 0, 0, 0,      1, 0, 2046, 'hCAFE, 2046, 0,     0);
        tv[32] = mk(1, 1, 2, 0, 0, 0,      1, 0, 2045, 'h0042, 2045, 0,     0);
        tv[33] = mk(1, 3, 3, 0, 0, 0,      0, 1, 2045, 0,      2044, 0,     0);
        tv[34] = mk(1, 2, 3, 0, 0, 0,      0, 1, 2046, 0,      2045, 0,     0);
        tv[35] = mk(0, 1, 3, 0, 0, 0,      0, 0, 0,    0,      2046, 0,     0);
        tv[36] = mk(1, 0, 0, 0, 0, 0,      0, 0, 0,    0,      2047, 0,     0);
        tv[37] = mk(1, 0, 0, 0, 0, 0,      0, 0, 0,    0,      2047, 0,     0);

        dc[0] = '{8,  16'h0000, 32'h0001_2345, 3'b000};
        dc[1] = '{9,  16'h0000, 32'h0001_2345, 3'b101};
        dc[2] = '{17, 16'h0000, 32'h0001_2345, 3'b101};
        dc[3] = '{22, 16'hBEEF, 32'h0001_2345, 3'b101};
        dc[4] = '{27, 16'h0000, 32'h0001_2345, 3'b101};
        dc[5] = '{36, 16'h0000, 32'h0000_0000, 3'b000};

        @(posedge clk);
        #1 clr = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst_n     = tv[i].rst;
            seq_phase = tv[i].ph;
            seq_dir   = tv[i].dir;
            push_req  = tv[i].push;
            pop_req   = tv[i].pop;
            push_data = tv[i].pd;
            pc_in     = (i >= 30) ? 32'hCAFE_0042 : 32'h0001_2345;
            flags_in  = (i >= 30) ? 3'b010 : 3'b101;
            #2;
            chk($sformatf("row%0d mem_we", i), 32'(mem_we), 32'(tv[i].we));
            chk($sformatf("row%0d mem_re", i), 32'(mem_re), 32'(tv[i].re));
            chk($sformatf("row%0d mem_addr", i), 32'(mem_addr), 32'(tv[i].addr));
            chk($sformatf("row%0d mem_wdata", i), 32'(mem_wdata), 32'(tv[i].wd));
            chk($sformatf("row%0d sp", i), 32'(sp), 32'(tv[i].sp));
            chk($sformatf("row%0d valids", i), 32'({pop_valid, pc_valid, flags_valid}),
                32'(tv[i].vld));
            chk($sformatf("row%0d stack_err", i), 32'(stack_err), 32'(tv[i].err));
            for (int j = 0; j < ND; j++) begin
                if (dc[j].row == i) begin
                    chk($sformatf("row%0d pop_data", i), 32'(pop_data), 32'(dc[j].pd));
                    chk($sformatf("row%0d pc_out", i), pc_out, dc[j].pc);
                    chk($sformatf("row%0d flags_out", i), 32'(flags_out), 32'(dc[j].fl));
                end
            end
            if (i == 13) begin
                chk("call mem[2047]", 32'(mem[2047]), 32'h0001);
                chk("call mem[2046]", 32'(mem[2046]), 32'h2345);
            end
        end

        // Back-to-back single pops return words in LIFO order on consecutive cycles.
        single(1'b1, 1'b0, 16'h1111);
        chk("b2b push1 addr", 32'(mem_addr), 32'd2047);
        single(1'b1, 1'b0, 16'h2222);
        chk("b2b push2 addr", 32'(mem_addr), 32'd2046);
        single(1'b0, 1'b1, 16'h0000);
        chk("b2b pop1 re", 32'(mem_re), 32'd1);
        chk("b2b pop1 addr", 32'(mem_addr), 32'd2046);
        single(1'b0, 1'b1, 16'h0000);
        chk("b2b pop2 addr", 32'(mem_addr), 32'd2047);
        chk("b2b pop2 early valid", 32'(pop_valid), 32'd0);
        single(1'b0, 1'b0, 16'h0000);
        chk("b2b first valid", 32'(pop_valid), 32'd1);
        chk("b2b first data", 32'(pop_data), 32'h2222);
        single(1'b0, 1'b0, 16'h0000);
        chk("b2b second valid", 32'(pop_valid), 32'd1);
        chk("b2b second data", 32'(pop_data), 32'h1111);
        single(1'b0, 1'b0, 16'h0000);
        chk("b2b valid drop", 32'(pop_valid), 32'd0);
        chk("b2b data hold", 32'(pop_data), 32'h1111);
        chk("b2b sp", 32'(sp), 32'd2047);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
